// File: rtl/relock_signal_avg.sv
// relock_signal_avg: decimated boxcar average of the lock-monitor signal, passed straight through until the window fills
module relock_signal_avg #(
  parameter int LOG2N = 4,
  parameter int DEC_BITS = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                on_i,
  input  logic [DEC_BITS-1:0] dec_i,
  input  logic signed [13:0]  signal_i,
  output logic signed [13:0]  signal_o,
  output logic                valid_o,
  output logic                filled_o
);
  localparam int N = 1 << LOG2N;
  localparam int AW = 14 + LOG2N;
  localparam logic [LOG2N:0] FULL = (LOG2N + 1)'(N);
  logic [DEC_BITS-1:0] dec_cnt_q, dec_cnt_d;
  logic [LOG2N-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2N:0] fill_cnt_q, fill_cnt_d;
  logic signed [AW-1:0] acc_q, acc_d, sig_ext, old_ext;
  logic signed [13:0] signal_q, signal_d;
  logic signed [13:0] buf_q [N];
  logic stb_q, stb_d, valid_q, valid_d, filled_q, filled_d, strobe;
  // decimation, window bookkeeping and output selection; on_i low clears everything but keeps bypassing
  always_comb begin
    strobe = on_i && (dec_cnt_q >= dec_i);
    sig_ext = $signed({{LOG2N{signal_i[13]}}, signal_i});
    old_ext = filled_q ? $signed({{LOG2N{buf_q[wr_ptr_q][13]}}, buf_q[wr_ptr_q]}) : '0;
    dec_cnt_d = (!on_i || strobe) ? '0 : dec_cnt_q + 1'b1;
    wr_ptr_d = !on_i ? '0 : strobe ? wr_ptr_q + 1'b1 : wr_ptr_q;
    fill_cnt_d = !on_i ? '0 : (strobe && !filled_q) ? fill_cnt_q + 1'b1 : fill_cnt_q;
    acc_d = !on_i ? '0 : strobe ? acc_q + sig_ext - old_ext : acc_q;
    filled_d = fill_cnt_d == FULL;
    stb_d = strobe;
    valid_d = on_i && stb_q && filled_q;
    signal_d = (on_i && filled_q) ? (stb_q ? acc_q[LOG2N +: 14] : signal_q) : signal_i;
  end
  // state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dec_cnt_q <= '0;
      wr_ptr_q <= '0;
      fill_cnt_q <= '0;
      acc_q <= '0;
      signal_q <= '0;
      stb_q <= 1'b0;
      valid_q <= 1'b0;
      filled_q <= 1'b0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
      wr_ptr_q <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      acc_q <= acc_d;
      signal_q <= signal_d;
      stb_q <= stb_d;
      valid_q <= valid_d;
      filled_q <= filled_d;
    end
  end
  // sample window storage; the old entry is read combinationally before this write
  always_ff @(posedge clk_i) begin
    if (!rst_i && strobe) buf_q[wr_ptr_q] <= signal_i;
  end
  assign signal_o = signal_q;
  assign valid_o = valid_q;
  assign filled_o = filled_q;
endmodule

// File: tb/tb_relock_signal_avg.sv
// tb_relock_signal_avg: directed checks of bypass, fill, averaging, decimation, disable and reset
module tb_relock_signal_avg;
  logic clk = 1'b0;
  logic rst, on;
  logic [15:0] dec;
  logic signed [13:0] sig_in, sig_out;
  logic valid, filled;
  int checks = 0;
  int failures = 0;
  relock_signal_avg #(.LOG2N(4), .DEC_BITS(16)) dut (
    .clk_i(clk), .rst_i(rst), .on_i(on), .dec_i(dec),
    .signal_i(sig_in), .signal_o(sig_out), .valid_o(valid), .filled_o(filled)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    logic any_valid;
    rst = 1'b1; on = 1'b0; dec = 16'd0; sig_in = 14'sd0;
    tick();
    tick();
    chk("reset_signal", sig_out, 0);
    chk("reset_valid", {31'b0, valid}, 0);
    chk("reset_filled", {31'b0, filled}, 0);
    rst = 1'b0; on = 1'b1; sig_in = 14'sd0;
    tick();
    chk("bypass_0", sig_out, 0);
    sig_in = 14'sd500;
    tick();
    chk("bypass_500", sig_out, 500);
    chk("bypass_valid", {31'b0, valid}, 0);
    chk("bypass_filled", {31'b0, filled}, 0);
    on = 1'b0; sig_in = 14'sd100;
    tick();
    chk("off_signal", sig_out, 100);
    chk("off_filled", {31'b0, filled}, 0);
    on = 1'b1;
    for (int k = 1; k <= 15; k++) tick();
    chk("fill15_filled", {31'b0, filled}, 0);
    tick();
    chk("fill16_filled", {31'b0, filled}, 1);
    chk("fill16_valid", {31'b0, valid}, 0);
    chk("fill16_signal", sig_out, 100);
    tick();
    chk("avg100_valid", {31'b0, valid}, 1);
    chk("avg100_signal", sig_out, 100);
    tick();
    chk("avg100_valid2", {31'b0, valid}, 1);
    for (int i = 0; i < 20; i++) begin
      sig_in = (i % 2) ? -14'sd4 : -14'sd3;
      tick();
    end
    chk("alt_floor", sig_out, -4);
    chk("alt_valid", {31'b0, valid}, 1);
    sig_in = 14'sd8191;
    for (int i = 0; i < 17; i++) tick();
    chk("max_pos", sig_out, 8191);
    sig_in = -14'sd8192;
    for (int i = 0; i < 17; i++) tick();
    chk("max_neg", sig_out, -8192);
    dec = 16'd3;
    for (int t = 1; t <= 13; t++) begin
      tick();
      chk($sformatf("dec3_valid_t%0d", t), {31'b0, valid}, (t % 4 == 1) ? 1 : 0);
    end
    chk("dec3_signal", sig_out, -8192);
    tick();
    dec = 16'd1;
    tick();
    chk("dec_drop_t15", {31'b0, valid}, 0);
    tick();
    chk("dec_drop_t16", {31'b0, valid}, 1);
    dec = 16'd0; on = 1'b0; sig_in = 14'sd77;
    tick();
    chk("dis_filled", {31'b0, filled}, 0);
    chk("dis_signal", sig_out, 77);
    chk("dis_valid", {31'b0, valid}, 0);
    on = 1'b1; sig_in = 14'sd200;
    any_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      any_valid |= valid;
    end
    chk("refill_no_valid", {31'b0, any_valid}, 0);
    chk("refill_filled", {31'b0, filled}, 1);
    tick();
    chk("refill_valid", {31'b0, valid}, 1);
    chk("refill_signal", sig_out, 200);
    rst = 1'b1; sig_in = 14'sd999;
    tick();
    chk("rst_signal", sig_out, 0);
    chk("rst_valid", {31'b0, valid}, 0);
    chk("rst_filled", {31'b0, filled}, 0);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      sig_in = 14'(k * 10);
      tick();
    end
    chk("ramp_filled", {31'b0, filled}, 1);
    chk("ramp_bypass", sig_out, 150);
    sig_in = 14'sd1000;
    tick();
    chk("ramp_avg", sig_out, 75);
    chk("ramp_valid", {31'b0, valid}, 1);
    tick();
    chk("ramp_slide", sig_out, 137);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
